// File: rtl/divider_arbiter.sv
// Round-robin front end that shares one multi-cycle unsigned divider between NUM_REQ requesters.
// Answers divide-by-zero locally and forces an all-ones result if the divider hangs in WAIT.
module divider_arbiter #(
  parameter int N       = 8,
  parameter int NUM_REQ = 4,
  parameter int TIMEOUT = 32
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [NUM_REQ-1:0]     req_valid,
  input  logic [NUM_REQ*N-1:0]   req_dividend,
  input  logic [NUM_REQ*N-1:0]   req_divisor,
  output logic [NUM_REQ-1:0]     req_ready,
  output logic [NUM_REQ-1:0]     rsp_valid,
  output logic [N-1:0]           rsp_result,
  output logic                   div_start,
  output logic [N-1:0]           div_dividend,
  output logic [N-1:0]           div_divisor,
  input  logic [N-1:0]           div_result,
  input  logic                   div_done,
  output logic                   busy,
  output logic                   timeout_err
);

  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [IW-1:0] LAST_REQ = IW'(NUM_REQ - 1);
  localparam logic [TW-1:0] T_LAST   = TW'(TIMEOUT - 1);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

  state_t        state, state_nxt;
  logic [IW-1:0] rr_ptr;
  logic [IW-1:0] grant_idx;
  logic [N-1:0]  op_a, op_b, result;
  logic [TW-1:0] timer;

  logic          win_vld;
  logic [IW-1:0] win_idx;
  logic [N-1:0]  win_a, win_b;

  // Lowest valid index overall, then overridden by the lowest valid index at or after rr_ptr.
  always_comb begin
    win_vld = 1'b0;
    win_idx = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (req_valid[i]) begin
        win_vld = 1'b1;
        win_idx = IW'(i);
      end
    end
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (req_valid[i] && (IW'(i) >= rr_ptr)) win_idx = IW'(i);
    end
  end

  assign win_a = req_dividend[win_idx*N +: N];
  assign win_b = req_divisor[win_idx*N +: N];

  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (win_vld) state_nxt = (win_b == '0) ? S_RESP : S_ISSUE;
      S_ISSUE: state_nxt = S_WAIT;
      S_WAIT:  if (div_done || (timer == T_LAST)) state_nxt = S_RESP;
      S_RESP:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rr_ptr      <= '0;
      grant_idx   <= '0;
      op_a        <= '0;
      op_b        <= '0;
      result      <= '0;
      timer       <= '0;
      timeout_err <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (win_vld) begin
            grant_idx <= win_idx;
            op_a      <= win_a;
            op_b      <= win_b;
            rr_ptr    <= (win_idx == LAST_REQ) ? '0 : win_idx + 1'b1;
            if (win_b == '0) result <= '1;
          end
        end
        S_ISSUE: timer <= '0;
        S_WAIT: begin
          timer <= timer + 1'b1;
          // A completion landing on the last timer cycle still counts as a good result.
          if (div_done) begin
            result <= div_result;
          end else if (timer == T_LAST) begin
            result      <= '1;
            timeout_err <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    req_ready    = '0;
    rsp_valid    = '0;
    rsp_result   = '0;
    div_start    = 1'b0;
    div_dividend = '0;
    div_divisor  = '0;
    busy         = (state != S_IDLE);
    if (state == S_IDLE && win_vld) req_ready[win_idx] = 1'b1;
    if (state != S_IDLE) begin
      div_dividend = op_a;
      div_divisor  = op_b;
    end
    if (state == S_ISSUE) div_start = 1'b1;
    if (state == S_RESP) begin
      rsp_valid[grant_idx] = 1'b1;
      rsp_result           = result;
    end
  end

endmodule

// File: tb/tb_divider_arbiter.sv
// Bench for divider_arbiter: divider stub, transaction-level reference model checked every cycle,
// directed scenarios pinned with literal values, then randomized traffic.
module tb_divider_arbiter;
  localparam int N  = 8;
  localparam int NR = 4;
  localparam int TO = 32;

  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic [NR-1:0]   req_valid = '0;
  logic [NR*N-1:0] req_dividend = '0;
  logic [NR*N-1:0] req_divisor = '0;
  logic [NR-1:0]   req_ready, rsp_valid;
  logic [N-1:0]    rsp_result, div_dividend, div_divisor;
  logic            div_start, busy, timeout_err;
  logic [N-1:0]    div_result = '0;
  logic            div_done = 1'b0;

  divider_arbiter #(.N(N), .NUM_REQ(NR), .TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_dividend(req_dividend),
    .req_divisor(req_divisor), .req_ready(req_ready), .rsp_valid(rsp_valid),
    .rsp_result(rsp_result), .div_start(div_start), .div_dividend(div_dividend),
    .div_divisor(div_divisor), .div_result(div_result), .div_done(div_done),
    .busy(busy), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  // divider stub state
  bit         stub_hang_all = 0;
  bit         rand_stub = 0;
  bit         st_pend = 0;
  int         st_at = 0;
  logic [N-1:0] st_q = '0;
  logic [N-1:0] st_a_seen = '0, st_b_seen = '0;
  int         n_starts = 0, n_dones = 0;

  // reference model state
  bit           m_busy = 0;
  int           m_g = 0, m_issue = -1, m_resp = -1, m_rr = 0;
  logic [N-1:0] m_a = '0, m_b = '0, m_res = '0;
  bit           m_err = 0;

  int q_g[$], q_hcyc[$], q_rv[$], q_res[$], q_rcyc[$];
  logic [NR-1:0] last_hs = '0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    logic [NR-1:0] exp_rdy;
    logic [NR-1:0] rv;
    int w, j;
    cyc++;
    if (div_start === 1'b1) begin
      n_starts++;
      st_a_seen = div_dividend;
      st_b_seen = div_divisor;
      st_pend   = !(stub_hang_all || (rand_stub && $urandom_range(15) == 0));
      st_at     = cyc + (rand_stub ? int'($urandom_range(N + 2, 1)) : N + 2);
      st_q      = (div_divisor == '0) ? '1 : div_dividend / div_divisor;
    end
    div_done   = 1'b0;
    div_result = N'($urandom);
    if (st_pend && cyc == st_at) begin
      div_done   = 1'b1;
      div_result = st_q;
      st_pend    = 0;
      n_dones++;
    end

    if (reset) begin
      m_busy  = 0;
      m_rr    = 0;
      m_err   = 0;
      last_hs = '0;
    end else begin
      last_hs = req_valid & req_ready;
      chk("timeout_err", timeout_err, m_err);
      if (!m_busy) begin
        rv = req_valid;
        w = -1;
        for (int k = 0; k < NR; k++) begin
          j = (m_rr + k) % NR;
          if (w < 0 && rv[j]) w = j;
        end
        exp_rdy = '0;
        if (w >= 0) exp_rdy[w] = 1'b1;
        chk("req_ready", req_ready, exp_rdy);
        chk("busy_idle", busy, 0);
        chk("start_idle", div_start, 0);
        chk("dividend_idle", div_dividend, 0);
        chk("divisor_idle", div_divisor, 0);
        chk("rsp_valid_idle", rsp_valid, 0);
        chk("rsp_result_idle", rsp_result, 0);
        if (w >= 0) begin
          m_busy = 1;
          m_g    = w;
          m_a    = req_dividend[w*N +: N];
          m_b    = req_divisor[w*N +: N];
          m_rr   = (w + 1) % NR;
          q_g.push_back(w);
          q_hcyc.push_back(cyc);
          if (m_b == '0) begin
            m_resp  = cyc + 1;
            m_res   = '1;
            m_issue = -1;
          end else begin
            m_issue = cyc + 1;
            m_resp  = -1;
          end
        end
      end else begin
        chk("req_ready_busy", req_ready, 0);
        chk("busy", busy, 1);
        chk("div_start", div_start, (cyc == m_issue));
        chk("div_dividend", div_dividend, m_a);
        chk("div_divisor", div_divisor, m_b);
        if (cyc == m_resp) begin
          chk("rsp_valid", rsp_valid, NR'(1) << m_g);
          chk("rsp_result", rsp_result, m_res);
          m_busy = 0;
        end else begin
          chk("rsp_valid_quiet", rsp_valid, 0);
          chk("rsp_result_quiet", rsp_result, 0);
          if (m_issue >= 0 && m_resp < 0 && cyc > m_issue) begin
            if (div_done) begin
              m_resp = cyc + 1;
              m_res  = div_result;
            end else if (cyc == m_issue + TO) begin
              m_resp = cyc + 1;
              m_res  = '1;
              m_err  = 1;
            end
          end
        end
      end
      if (rsp_valid != '0) begin
        q_rv.push_back(int'(rsp_valid));
        q_res.push_back(int'(rsp_result));
        q_rcyc.push_back(cyc);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
    req_valid = req_valid & ~last_hs;
  endtask

  task automatic set_req(input int i, input int a, input int b);
    req_valid[i] = 1'b1;
    req_dividend[i*N +: N] = N'(a);
    req_divisor[i*N +: N]  = N'(b);
  endtask

  task automatic clear_logs();
    q_g.delete(); q_hcyc.delete(); q_rv.delete(); q_res.delete(); q_rcyc.delete();
  endtask

  task automatic do_reset();
    req_valid = '0;
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
    step();
    clear_logs();
  endtask

  task automatic wait_rsp(input int n, input int budget);
    int c;
    c = 0;
    while (q_rv.size() < n && c < budget) begin
      step();
      c++;
    end
    chk("wait_rsp", (q_rv.size() >= n), 1);
  endtask

  task automatic get_rsp(output int g, output int rv, output int res, output int lat);
    g = -1; rv = -1; res = -1; lat = -1;
    if (q_g.size() > 0 && q_rv.size() > 0) begin
      g   = q_g.pop_front();
      rv  = q_rv.pop_front();
      res = q_res.pop_front();
      lat = q_rcyc.pop_front() - q_hcyc.pop_front();
    end
  endtask

  initial begin
    int g, rv, res, lat, s0, d0, c;
    int exp_q[4];
    exp_q = '{33, 10, 15, 0};

    repeat (3) step();
    reset = 1'b0;
    step();
    chk("rst_busy", busy, 0);
    chk("rst_terr", timeout_err, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_div_start", div_start, 0);
    chk("rst_dividend", div_dividend, 0);

    // single request on requester 2
    clear_logs();
    s0 = n_starts;
    set_req(2, 200, 7);
    wait_rsp(1, 40);
    get_rsp(g, rv, res, lat);
    chk("t1_grant", g, 2);
    chk("t1_rsp_valid", rv, 4);
    chk("t1_result", res, 28);
    chk("t1_latency", lat, 12);
    chk("t1_starts", n_starts - s0, 1);
    chk("t1_op_a", st_a_seen, 200);
    chk("t1_op_b", st_b_seen, 7);

    // all four valid from reset
    do_reset();
    set_req(0, 100, 3);
    set_req(1, 90, 9);
    set_req(2, 255, 16);
    set_req(3, 7, 8);
    wait_rsp(4, 120);
    for (int k = 0; k < 4; k++) begin
      get_rsp(g, rv, res, lat);
      chk("t2_grant", g, k);
      chk("t2_rsp_valid", rv, 1 << k);
      chk("t2_result", res, exp_q[k]);
    end

    // divide by zero, then pointer check
    do_reset();
    s0 = n_starts;
    set_req(1, 50, 0);
    wait_rsp(1, 10);
    get_rsp(g, rv, res, lat);
    chk("t3_rsp_valid", rv, 2);
    chk("t3_result", res, 255);
    chk("t3_latency", lat, 1);
    chk("t3_starts", n_starts - s0, 0);
    set_req(1, 9, 3);
    set_req(2, 9, 3);
    wait_rsp(2, 60);
    get_rsp(g, rv, res, lat);
    chk("t3_rr_next", g, 2);

    // hung divider
    do_reset();
    stub_hang_all = 1;
    set_req(0, 10, 2);
    wait_rsp(1, 80);
    get_rsp(g, rv, res, lat);
    chk("t4_rsp_valid", rv, 1);
    chk("t4_result", res, 255);
    chk("t4_latency", lat, 34);
    chk("t4_terr", timeout_err, 1);
    stub_hang_all = 0;
    set_req(1, 20, 4);
    wait_rsp(1, 40);
    get_rsp(g, rv, res, lat);
    chk("t4_good_result", res, 5);
    chk("t4_terr_sticky", timeout_err, 1);

    // reset during WAIT, stale completion afterwards
    do_reset();
    set_req(2, 40, 5);
    c = 0;
    while (q_g.size() == 0 && c < 20) begin step(); c++; end
    repeat (4) step();
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
    step();
    chk("t5_busy", busy, 0);
    chk("t5_terr", timeout_err, 0);
    chk("t5_div_start", div_start, 0);
    chk("t5_dividend", div_dividend, 0);
    chk("t5_rsp_valid", rsp_valid, 0);
    clear_logs();
    d0 = n_dones;
    repeat (12) step();
    chk("t5_stale_done_seen", n_dones - d0, 1);
    chk("t5_no_rsp", q_rv.size(), 0);
    set_req(1, 30, 6);
    set_req(3, 30, 6);
    wait_rsp(2, 60);
    get_rsp(g, rv, res, lat);
    chk("t5_first_grant", g, 1);
    chk("t5_result", res, 5);

    // round-robin after a grant to requester 3
    clear_logs();
    set_req(3, 64, 8);
    wait_rsp(1, 40);
    set_req(0, 64, 4);
    set_req(3, 64, 2);
    wait_rsp(3, 80);
    get_rsp(g, rv, res, lat);
    chk("t6_grant_a", g, 3);
    get_rsp(g, rv, res, lat);
    chk("t6_grant_b", g, 0);
    chk("t6_result_b", res, 16);
    get_rsp(g, rv, res, lat);
    chk("t6_grant_c", g, 3);

    // randomized traffic
    rand_stub = 1;
    for (int t = 0; t < 3000; t++) begin
      step();
      if ($urandom_range(499) == 0) begin
        reset = 1'b1;
        req_valid = '0;
        step();
        step();
        reset = 1'b0;
      end
      for (int i = 0; i < NR; i++) begin
        if (!req_valid[i] && $urandom_range(3) == 0)
          set_req(i, int'($urandom_range(255)),
                  ($urandom_range(7) == 0) ? 0 : int'($urandom_range(255, 1)));
        else if (req_valid[i] && $urandom_range(63) == 0)
          req_valid[i] = 1'b0;
      end
    end
    req_valid = '0;
    repeat (60) step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
